// File: rtl/axi_stream_extract_header_if.sv
// AXI-Stream style channel bundle: valid/ready handshake plus data, byte
// enables and last. Used for the input stream, the header channel and the
// realigned payload stream of axi_stream_extract_header.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD = 32
) ();
  localparam int BYTE_WD = DATA_WD / 8;

  logic               valid;
  logic               ready;
  logic [DATA_WD-1:0] data;
  logic [BYTE_WD-1:0] keep;
  logic               last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips a per-packet header of 1..W bytes from the front of an AXI-Stream
// packet. The header leaves right-aligned on its own channel; the remaining
// payload is re-packed MSB-aligned onto the output stream. Byte 0 of a beat
// sits in the top byte lane, keep bit W-1 enables it.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_cfg,
  input  logic [BYTE_CNT_WD-1:0]      hdr_len_m1,
  output logic                        ready_cfg,
  axi_stream_extract_header_if.slave  din,
  axi_stream_extract_header_if.master hdr,
  axi_stream_extract_header_if.master dout
);

  localparam int W      = DATA_BYTE_WD;
  // Byte counts 0..W need one bit more than hdr_len_m1.
  localparam int CNT_WD = BYTE_CNT_WD + 1;
  // Residual plus incoming bytes reach 2W-1.
  localparam int SUM_WD = CNT_WD + 1;
  localparam logic [CNT_WD-1:0] W_CNT = CNT_WD'(W);
  localparam logic [SUM_WD-1:0] W_SUM = SUM_WD'(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BODY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Per-packet header length and the carried-over payload bytes.
  logic [CNT_WD-1:0]  hdr_len, hdr_len_nxt;
  logic [DATA_WD-1:0] res_data, res_data_nxt;
  logic [CNT_WD-1:0]  res_cnt, res_cnt_nxt;

  // Registered header channel.
  logic               hdr_valid;
  logic [DATA_WD-1:0] hdr_data;
  logic [W-1:0]       hdr_keep;

  // Registered payload channel.
  logic               out_valid;
  logic [DATA_WD-1:0] out_data;
  logic [W-1:0]       out_keep;
  logic               out_last;

  // Load requests and next values from the control process.
  logic               hdr_load;
  logic [DATA_WD-1:0] hdr_data_nxt;
  logic [W-1:0]       hdr_keep_nxt;
  logic               out_load;
  logic [DATA_WD-1:0] out_data_nxt;
  logic [W-1:0]       out_keep_nxt;
  logic               out_last_nxt;
  logic               din_ready;

  // Datapath helpers.
  logic                 hdr_free;
  logic                 out_free;
  logic [DATA_WD-1:0]   in_data;
  logic [CNT_WD-1:0]    in_cnt;
  logic [CNT_WD-1:0]    hdr_cnt;
  logic [SUM_WD-1:0]    sum_cnt;
  logic [2*DATA_WD-1:0] merged;

  // Enables for the top cnt byte lanes (payload is MSB-aligned).
  function automatic logic [W-1:0] top_mask(input logic [CNT_WD-1:0] cnt);
    return ~({W{1'b1}} >> cnt);
  endfunction

  // Enables for the bottom cnt byte lanes (header is right-aligned).
  function automatic logic [W-1:0] low_mask(input logic [CNT_WD-1:0] cnt);
    return ~({W{1'b1}} << cnt);
  endfunction

  // A register slot can take a new beat when empty or being drained now.
  assign hdr_free = !hdr_valid || hdr.ready;
  assign out_free = !out_valid || dout.ready;

  // Zero disabled lanes and count enabled bytes; keep masks come from counts.
  always_comb begin
    in_data = '0;
    in_cnt  = '0;
    for (int i = 0; i < W; i++) begin
      if (din.keep[i]) begin
        in_data[8*i +: 8] = din.data[8*i +: 8];
        in_cnt            = in_cnt + CNT_WD'(1);
      end
    end
  end

  // A short first beat delivers only the bytes that actually arrived.
  assign hdr_cnt = (in_cnt < hdr_len) ? in_cnt : hdr_len;
  assign sum_cnt = SUM_WD'(res_cnt) + SUM_WD'(in_cnt);
  // Residual bytes first, incoming bytes appended; upper half is the
  // outgoing beat, lower half the new residual.
  assign merged  = {res_data, {DATA_WD{1'b0}}}
                 | ({in_data, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});

  // State register and per-packet datapath state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  // NOTE: the residual is reset along with the control state; it is only a
  // single beat wide, and a clean value keeps post-reset beats deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hdr_len  <= '0;
      res_data <= '0;
      res_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      hdr_len  <= hdr_len_nxt;
      res_data <= res_data_nxt;
      res_cnt  <= res_cnt_nxt;
    end
  end

  // Next state, handshakes and register load requests.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt    = state;
    ready_cfg    = 1'b0;
    din_ready    = 1'b0;
    hdr_len_nxt  = hdr_len;
    res_data_nxt = res_data;
    res_cnt_nxt  = res_cnt;
    hdr_load     = 1'b0;
    hdr_data_nxt = '0;
    hdr_keep_nxt = '0;
    out_load     = 1'b0;
    out_data_nxt = '0;
    out_keep_nxt = '0;
    out_last_nxt = 1'b0;

    case (state)
      IDLE: begin
        ready_cfg = 1'b1;
        if (valid_cfg) begin
          hdr_len_nxt = CNT_WD'(hdr_len_m1) + CNT_WD'(1);
          state_nxt   = HDR;
        end
      end

      HDR: begin
        // Only the header slot gates the first beat; payload is not emitted.
        din_ready = hdr_free;
        if (din.valid && hdr_free) begin
          hdr_load     = 1'b1;
          hdr_data_nxt = in_data >> {W_CNT - hdr_cnt, 3'b000};
          hdr_keep_nxt = low_mask(hdr_cnt);
          res_data_nxt = in_data << {hdr_len, 3'b000};
          res_cnt_nxt  = (in_cnt > hdr_len) ? in_cnt - hdr_len : '0;
          if (in_cnt < hdr_len) begin
            state_nxt = IDLE;
          end else if (!din.last) begin
            state_nxt = BODY;
          end else if (in_cnt != hdr_len) begin
            state_nxt = FLUSH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      BODY: begin
        din_ready = out_free;
        if (din.valid && out_free) begin
          out_load     = 1'b1;
          out_data_nxt = merged[2*DATA_WD-1 -: DATA_WD];
          res_data_nxt = merged[DATA_WD-1:0];
          if (sum_cnt <= W_SUM) begin
            // Everything fits in one beat; nothing is carried over.
            out_keep_nxt = top_mask(sum_cnt[CNT_WD-1:0]);
            res_cnt_nxt  = '0;
            out_last_nxt = din.last;
            if (din.last) begin
              state_nxt = IDLE;
            end
          end else begin
            out_keep_nxt = '1;
            res_cnt_nxt  = CNT_WD'(sum_cnt - W_SUM);
            if (din.last) begin
              state_nxt = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        // Input stays stalled until the carried-over tail is emitted.
        if (out_free) begin
          out_load     = 1'b1;
          out_data_nxt = res_data;
          out_keep_nxt = top_mask(res_cnt);
          out_last_nxt = 1'b1;
          res_data_nxt = '0;
          res_cnt_nxt  = '0;
          state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Header output register: load on first-beat accept, drop valid on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
      hdr_keep  <= '0;
    end else if (hdr_load) begin
      hdr_valid <= 1'b1;
      hdr_data  <= hdr_data_nxt;
      hdr_keep  <= hdr_keep_nxt;
    end else if (hdr.ready) begin
      hdr_valid <= 1'b0;
    end
  end

  // Payload output register: a same-cycle pop and push keeps one beat/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_data  <= out_data_nxt;
      out_keep  <= out_keep_nxt;
      out_last  <= out_last_nxt;
    end else if (dout.ready) begin
      out_valid <= 1'b0;
    end
  end

  assign din.ready  = din_ready;

  assign hdr.valid  = hdr_valid;
  assign hdr.data   = hdr_data;
  assign hdr.keep   = hdr_keep;
  assign hdr.last   = 1'b1;

  assign dout.valid = out_valid;
  assign dout.data  = out_data;
  assign dout.keep  = out_keep;
  assign dout.last  = out_last;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Self-checking bench for axi_stream_extract_header (W=4). Directed packets
// with hand-computed header/payload beats, a randomised stream checked
// against a byte-level reference, stall stability and a mid-packet reset.
module tb_axi_stream_extract_header;
  localparam int DATA_WD = 32;
  localparam int W       = DATA_WD / 8;
  localparam int BCW     = $clog2(W);
  localparam int TIMEOUT = 1000;

  logic           clk;
  logic           rst_n;
  logic           valid_cfg;
  logic [BCW-1:0] hdr_len_m1;
  logic           ready_cfg;

  axi_stream_extract_header_if #(.DATA_WD(DATA_WD)) din_if  ();
  axi_stream_extract_header_if #(.DATA_WD(DATA_WD)) hdr_if  ();
  axi_stream_extract_header_if #(.DATA_WD(DATA_WD)) dout_if ();

  axi_stream_extract_header #(.DATA_WD(DATA_WD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_cfg  (valid_cfg),
    .hdr_len_m1 (hdr_len_m1),
    .ready_cfg  (ready_cfg),
    .din        (din_if),
    .hdr        (hdr_if),
    .dout       (dout_if)
  );

  int checks   = 0;
  int failures = 0;

  // 0: ready_out always high, 1: random, 2: held low
  int out_mode = 0;
  // cycles ready_hdr is still held low
  int hdr_hold = 0;

  logic [63:0] got_out[$];
  logic [63:0] got_hdr[$];
  logic [63:0] exp_out[$];
  logic [63:0] exp_hdr[$];
  logic [7:0]  pkt[0:63];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ob(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {27'd0, d, k, l};
  endfunction

  function automatic logic [63:0] hb(input logic [31:0] d, input logic [3:0] k);
    return {28'd0, d, k};
  endfunction

  // Consumer readiness, updated just after each rising edge.
  initial begin
    dout_if.ready = 1'b1;
    hdr_if.ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       dout_if.ready = 1'b1;
        1:       dout_if.ready = 1'($urandom_range(0, 1));
        default: dout_if.ready = 1'b0;
      endcase
      if (hdr_hold > 0) begin
        hdr_if.ready = 1'b0;
        hdr_hold--;
      end else begin
        hdr_if.ready = 1'b1;
      end
    end
  end

  // Output monitor on the falling edge: records accepted beats and checks
  // that a stalled beat is still presented unchanged one cycle later.
  initial begin
    logic        out_stall;
    logic        hdr_stall;
    logic [63:0] out_prev;
    logic [63:0] hdr_prev;
    out_stall = 1'b0;
    hdr_stall = 1'b0;
    out_prev  = '0;
    hdr_prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_stall = 1'b0;
        hdr_stall = 1'b0;
      end else begin
        if (out_stall) begin
          check("out_hold_valid", dout_if.valid, 1);
          check("out_hold_beat", ob(dout_if.data, dout_if.keep, dout_if.last), out_prev);
        end
        if (hdr_stall) begin
          check("hdr_hold_valid", hdr_if.valid, 1);
          check("hdr_hold_beat", hb(hdr_if.data, hdr_if.keep), hdr_prev);
        end
        if (dout_if.valid && dout_if.ready) got_out.push_back(ob(dout_if.data, dout_if.keep, dout_if.last));
        if (hdr_if.valid && hdr_if.ready) got_hdr.push_back(hb(hdr_if.data, hdr_if.keep));
        out_stall = dout_if.valid && !dout_if.ready;
        hdr_stall = hdr_if.valid && !hdr_if.ready;
        out_prev  = ob(dout_if.data, dout_if.keep, dout_if.last);
        hdr_prev  = hb(hdr_if.data, hdr_if.keep);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_cfg(input int h);
    int waited = 0;
    valid_cfg  = 1'b1;
    hdr_len_m1 = BCW'(h - 1);
    @(negedge clk);
    while (!ready_cfg && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= TIMEOUT) check("cfg_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_cfg = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited = 0;
    din_if.valid = 1'b1;
    din_if.data  = d;
    din_if.keep  = k;
    din_if.last  = l;
    @(negedge clk);
    while (!din_if.ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= TIMEOUT) check("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    din_if.valid = 1'b0;
  endtask

  // Wait for all expected beats (bounded), allow stray extras to show up,
  // then compare counts and contents and clear the queues.
  task automatic drain(input string tag);
    int waited = 0;
    while ((got_hdr.size() < exp_hdr.size() || got_out.size() < exp_out.size())
           && waited < 4 * TIMEOUT) begin
      @(posedge clk);
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_hdr_count"}, got_hdr.size(), exp_hdr.size());
    check({tag, "_out_count"}, got_out.size(), exp_out.size());
    for (int i = 0; i < exp_hdr.size() && i < got_hdr.size(); i++)
      check({tag, "_hdr"}, got_hdr[i], exp_hdr[i]);
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
      check({tag, "_out"}, got_out[i], exp_out[i]);
    got_hdr.delete();
    got_out.delete();
    exp_hdr.delete();
    exp_out.delete();
  endtask

  // Byte-level reference: header = first min(H, n0) bytes right-aligned;
  // payload = bytes H..len-1 re-chunked MSB-first into W-byte beats.
  task automatic expect_pkt(input int h, input int len);
    int          n0;
    int          hc;
    int          p;
    logic [31:0] d;
    logic [3:0]  k;
    n0 = (len < W) ? len : W;
    hc = (n0 < h) ? n0 : h;
    d  = '0;
    k  = '0;
    for (int i = 0; i < hc; i++) begin
      d = {d[23:0], pkt[i]};
      k = {k[2:0], 1'b1};
    end
    exp_hdr.push_back(hb(d, k));
    if (n0 >= h) begin
      p = h;
      while (p < len) begin
        d = '0;
        k = '0;
        for (int j = 0; j < W; j++) begin
          d = {d[23:0], (p + j < len) ? pkt[p + j] : 8'h00};
          k = {k[2:0], (p + j < len)};
        end
        p += W;
        exp_out.push_back(ob(d, k, p >= len));
      end
    end
  endtask

  // Sends pkt[0:len-1]; disabled lanes carry garbage, beats get random gaps.
  task automatic send_pkt(input int h, input int len);
    logic [31:0] d;
    logic [3:0]  k;
    int          nb;
    send_cfg(h);
    nb = (len + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < W; j++) begin
        if (b * W + j < len) begin
          d = {d[23:0], pkt[b * W + j]};
          k = {k[2:0], 1'b1};
        end else begin
          d = {d[23:0], 8'($urandom)};
          k = {k[2:0], 1'b0};
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(d, k, b == nb - 1);
    end
  endtask

  task automatic test_h3(input string tag);
    exp_hdr.push_back(hb(32'h00AABBCC, 4'b0111));
    exp_out.push_back(ob(32'hDD112233, 4'hF, 1'b0));
    exp_out.push_back(ob(32'h44556600, 4'hE, 1'b1));
    send_cfg(3);
    send_beat(32'hAABBCCDD, 4'hF, 1'b0);
    check({tag, "_hdr_latency"}, hdr_if.valid, 1);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h5566EEEE, 4'hC, 1'b1);
    drain(tag);
  endtask

  initial begin
    int h;
    int len;
    rst_n        = 1'b0;
    valid_cfg    = 1'b0;
    hdr_len_m1   = '0;
    din_if.valid = 1'b0;
    din_if.data  = '0;
    din_if.keep  = '0;
    din_if.last  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid_out", dout_if.valid, 0);
    check("rst_valid_hdr", hdr_if.valid, 0);
    check("rst_last_out", dout_if.last, 0);
    check("rst_data_out", dout_if.data, 0);
    check("rst_keep_out", dout_if.keep, 0);
    check("rst_keep_hdr", hdr_if.keep, 0);
    check("rst_ready_in", din_if.ready, 0);
    check("rst_ready_cfg", ready_cfg, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // H=3, three beats, short last beat
    test_h3("t1");

    // H=1, residual spills past the last beat -> FLUSH
    exp_hdr.push_back(hb(32'h000000A0, 4'b0001));
    exp_out.push_back(ob(32'hB0C0D001, 4'hF, 1'b0));
    exp_out.push_back(ob(32'h02030400, 4'hE, 1'b1));
    send_cfg(1);
    send_beat(32'hA0B0C0D0, 4'hF, 1'b0);
    send_beat(32'h01020304, 4'hF, 1'b1);
    drain("t2");

    // H=4, payload passes through with one cycle latency
    exp_hdr.push_back(hb(32'h01020304, 4'hF));
    exp_out.push_back(ob(32'h05060708, 4'hF, 1'b0));
    exp_out.push_back(ob(32'h090A0B0C, 4'hF, 1'b1));
    send_cfg(4);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b0);
    check("t3_out_latency", dout_if.valid, 1);
    check("t3_out_data", dout_if.data, 32'h05060708);
    send_beat(32'h090A0B0C, 4'hF, 1'b1);
    drain("t3");

    // H=2, header-only packet; back in IDLE right after the accept
    exp_hdr.push_back(hb(32'h0000AABB, 4'b0011));
    send_cfg(2);
    send_beat(32'hAABBEEEE, 4'hC, 1'b1);
    check("t4_ready_cfg", ready_cfg, 1);
    drain("t4");

    // H=4 but only 3 bytes arrive: short header, no payload
    exp_hdr.push_back(hb(32'h00AABBCC, 4'b0111));
    send_cfg(4);
    send_beat(32'hAABBCC77, 4'hE, 1'b1);
    check("t5_ready_cfg", ready_cfg, 1);
    drain("t5");

    // H=2, residual + last beat exactly fill one beat (no FLUSH)
    exp_hdr.push_back(hb(32'h00001122, 4'b0011));
    exp_out.push_back(ob(32'h33445566, 4'hF, 1'b1));
    send_cfg(2);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h5566ABCD, 4'hC, 1'b1);
    drain("t6");

    // H=1, single full last beat -> FLUSH straight from HDR
    exp_hdr.push_back(hb(32'h000000AA, 4'b0001));
    exp_out.push_back(ob(32'hBBCCDD00, 4'hE, 1'b1));
    send_cfg(1);
    send_beat(32'hAABBCCDD, 4'hF, 1'b1);
    drain("t7");

    // Random packets under random payload backpressure, header stalled 10 cycles
    out_mode = 1;
    hdr_hold = 10;
    for (int p = 0; p < 100; p++) begin
      h   = $urandom_range(1, 4);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
      expect_pkt(h, len);
      send_pkt(h, len);
    end
    drain("rand");
    out_mode = 0;

    // Asynchronous reset while in BODY with both output slots occupied
    out_mode = 2;
    hdr_hold = 1000;
    send_cfg(3);
    send_beat(32'hAABBCCDD, 4'hF, 1'b0);
    send_beat(32'h11223344, 4'hF, 1'b0);
    check("t8_pre_valid_out", dout_if.valid, 1);
    check("t8_pre_valid_hdr", hdr_if.valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8_rst_valid_out", dout_if.valid, 0);
    check("t8_rst_valid_hdr", hdr_if.valid, 0);
    check("t8_rst_ready_cfg", ready_cfg, 1);
    check("t8_rst_ready_in", din_if.ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    out_mode = 0;
    hdr_hold = 0;
    got_hdr.delete();
    got_out.delete();
    exp_hdr.delete();
    exp_out.delete();
    @(posedge clk);
    #1;
    test_h3("t8_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
